// File: rtl/crypt_sequencer.sv
// Encrypt-then-MAC control sequencer.
// Deserialises salt, password and message bytes into shift registers, hands
// them to the KDF, AES and HMAC engines, then streams the ciphertext block
// followed by the HMAC tag onto the byte output, least significant byte first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no key loaded; waiting for the first salt byte
// KEY_IN   | shifting in salt then password bytes as one contiguous burst
// KDF      | key derivation running; waiting for kdf_done
// MSG_WAIT | key held; waiting for the first byte of a message block
// MSG_IN   | shifting in the message block
// AES      | block cipher running; waiting for aes_done
// OUT_CT   | streaming ciphertext bytes
// GAP      | output idle; waiting for the HMAC tag to be latched
// OUT_MAC  | streaming tag bytes
module crypt_sequencer #(
   parameter int SALT_BYTES = 16,
   parameter int PW_BYTES   = 15,
   parameter int BLK_BYTES  = 16,
   parameter int TAG_BYTES  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [7:0]              i_data,
   input  logic                    i_mode,
   output logic [7:0]              o_data,
   output logic                    o_valid,
   output logic                    o_ien,
   output logic                    cfg_mode,
   output logic                    kdf_start,
   input  logic                    kdf_done,
   output logic [8*SALT_BYTES-1:0] salt_q,
   output logic [8*PW_BYTES-1:0]   pw_q,
   output logic                    aes_start,
   input  logic                    aes_done,
   input  logic [8*BLK_BYTES-1:0]  aes_ct,
   output logic [8*BLK_BYTES-1:0]  msg_q,
   output logic                    hmac_start,
   input  logic                    hmac_done,
   input  logic [8*TAG_BYTES-1:0]  hmac_tag
);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] KEY_IN   = 4'd1;
   localparam logic [3:0] KDF      = 4'd2;
   localparam logic [3:0] MSG_WAIT = 4'd3;
   localparam logic [3:0] MSG_IN   = 4'd4;
   localparam logic [3:0] AES      = 4'd5;
   localparam logic [3:0] OUT_CT   = 4'd6;
   localparam logic [3:0] GAP      = 4'd7;
   localparam logic [3:0] OUT_MAC  = 4'd8;

   localparam int KEY_BYTES = SALT_BYTES + PW_BYTES;

   // One shared byte counter serves key capture, message capture and both
   // output bursts; six bits cover the longest of them (32 tag bytes).
   localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
   localparam logic [5:0] SALT_N   = 6'(SALT_BYTES);
   localparam logic [5:0] BLK_LAST = 6'(BLK_BYTES - 1);
   localparam logic [5:0] BLK_N    = 6'(BLK_BYTES);
   localparam logic [5:0] TAG_N    = 6'(TAG_BYTES);

   logic [3:0]               state;
   logic [5:0]               cnt;
   logic [8*BLK_BYTES-1:0]   ct_q;
   logic [8*TAG_BYTES-1:0]   tag_q;
   logic                     tag_rdy;
   logic                     hmac_pend;
   logic [8*BLK_BYTES-1:0]   ct_sh;
   logic [8*TAG_BYTES-1:0]   tag_sh;

   // Select the output byte addressed by the burst counter.
   always_comb begin
      ct_sh  = ct_q >> {cnt, 3'b000};
      tag_sh = tag_q >> {cnt, 3'b000};
   end

   // Sequencer state, capture registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         salt_q     <= '0;
         pw_q       <= '0;
         msg_q      <= '0;
         ct_q       <= '0;
         tag_q      <= '0;
         tag_rdy    <= 1'b0;
         hmac_pend  <= 1'b0;
         cfg_mode   <= 1'b0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_ien      <= 1'b0;
         kdf_start  <= 1'b0;
         aes_start  <= 1'b0;
         hmac_start <= 1'b0;
      end else begin
         kdf_start  <= 1'b0;
         aes_start  <= 1'b0;
         hmac_start <= 1'b0;

         // The tag can arrive at any point between hmac_start and OUT_MAC
         // entry, so it is caught here independently of the state decode.
         if (hmac_pend && hmac_done) begin
            tag_q     <= hmac_tag;
            tag_rdy   <= 1'b1;
            hmac_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (i_start) begin
                  salt_q   <= {salt_q[8*SALT_BYTES-9:0], i_data};
                  pw_q     <= '0;
                  cfg_mode <= i_mode;
                  o_ien    <= 1'b1;
                  cnt      <= 6'd1;
                  state    <= KEY_IN;
               end
            end
            KEY_IN: begin
               if (i_start) begin
                  if (cnt < SALT_N) salt_q <= {salt_q[8*SALT_BYTES-9:0], i_data};
                  else              pw_q   <= {pw_q[8*PW_BYTES-9:0], i_data};
                  if (cnt == KEY_LAST) begin
                     kdf_start <= 1'b1;
                     cnt       <= '0;
                     state     <= KDF;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end else begin
                  // Truncated key burst: drop everything and start over.
                  salt_q <= '0;
                  pw_q   <= '0;
                  o_ien  <= 1'b0;
                  cnt    <= '0;
                  state  <= IDLE;
               end
            end
            KDF: begin
               if (kdf_done) begin
                  o_ien <= 1'b0;
                  cnt   <= '0;
                  state <= MSG_WAIT;
               end
            end
            MSG_WAIT: begin
               if (i_start) begin
                  msg_q <= {msg_q[8*BLK_BYTES-9:0], i_data};
                  cnt   <= 6'd1;
                  state <= MSG_IN;
               end else begin
                  cnt <= '0;
               end
            end
            MSG_IN: begin
               if (i_start) begin
                  msg_q <= {msg_q[8*BLK_BYTES-9:0], i_data};
                  if (cnt == BLK_LAST) begin
                     aes_start <= 1'b1;
                     cnt       <= '0;
                     state     <= AES;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end else begin
                  cnt   <= '0;
                  state <= MSG_WAIT;
               end
            end
            AES: begin
               if (aes_done) begin
                  // Byte 0 is presented straight from aes_ct so the burst
                  // starts on the same cycle hmac_start pulses.
                  ct_q       <= aes_ct;
                  hmac_start <= 1'b1;
                  hmac_pend  <= 1'b1;
                  tag_rdy    <= 1'b0;
                  o_ien      <= 1'b1;
                  o_valid    <= 1'b1;
                  o_data     <= aes_ct[7:0];
                  cnt        <= 6'd1;
                  state      <= OUT_CT;
               end
            end
            OUT_CT: begin
               if (cnt == BLK_N) begin
                  o_valid <= 1'b0;
                  o_data  <= '0;
                  cnt     <= '0;
                  state   <= GAP;
               end else begin
                  o_data <= ct_sh[7:0];
                  cnt    <= cnt + 6'd1;
               end
            end
            GAP: begin
               // Entering GAP always drops o_valid for at least this cycle,
               // so the tag burst gets its own rising edge.
               if (tag_rdy) begin
                  tag_rdy <= 1'b0;
                  o_valid <= 1'b1;
                  o_data  <= tag_q[7:0];
                  cnt     <= 6'd1;
                  state   <= OUT_MAC;
               end
            end
            OUT_MAC: begin
               if (cnt == TAG_N) begin
                  o_valid <= 1'b0;
                  o_data  <= '0;
                  o_ien   <= 1'b0;
                  cnt     <= '0;
                  state   <= MSG_WAIT;
               end else begin
                  o_data <= tag_sh[7:0];
                  cnt    <= cnt + 6'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
